// File: rtl/fbf_pkg.sv
// Shared definitions for the fbf matrix multiplier and its loaders/unloaders:
// element sizes, handshake state encoding and the packed-matrix bit layout.
package fbf_pkg;

  localparam int WORD_W = 32;
  localparam int DIM    = 4;
  localparam int MAT_W  = WORD_W * DIM * DIM;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACK    = 2'd1,
    STREAM = 2'd2
  } state_e;

  // Element (0,0) sits in the most significant word of the packed matrix.
  function automatic int elem_offset(input int r, input int c);
    return WORD_W * (DIM * DIM - 1 - (r * DIM + c));
  endfunction

endpackage

// File: rtl/fbf_elem_select.sv
// Combinational DIM*DIM:1 word mux: picks element (row_i, col_i) out of a
// packed matrix laid out with (0,0) in the most significant word.
module fbf_elem_select #(
  parameter int WORD_W = 32,
  parameter int DIM    = 4,
  parameter int IDX_W  = 2
) (
  input  logic [WORD_W*DIM*DIM-1:0] mat_i,
  input  logic [IDX_W-1:0]          row_i,
  input  logic [IDX_W-1:0]          col_i,
  output logic [WORD_W-1:0]         word_o
);

  localparam int N = DIM * DIM;

  int idx;

  always_comb begin
    idx    = int'(row_i) * DIM + int'(col_i);
    word_o = '0;
    for (int e = 0; e < N; e++) begin
      if (e == idx) begin
        word_o = mat_i[WORD_W*(N-1-e) +: WORD_W];
      end
    end
  end

endmodule

// File: rtl/fbf_result_unpacker.sv
// Takes one packed 4x4 matrix from the multiplier over a four-phase
// ready/ack handshake and streams it out one tagged word per transfer.
// Define FBF_UNPACK_COL_MAJOR_EN to stream in column-major order.
module fbf_result_unpacker #(
  parameter int WORD_W = 32,
  parameter int DIM    = 4,
  parameter int IDX_W  = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      result_ready,
  input  logic [WORD_W*DIM*DIM-1:0] result,
  output logic                      result_ack,
  output logic [WORD_W-1:0]         word_out,
  output logic                      word_valid,
  input  logic                      word_ready,
  output logic [IDX_W-1:0]          word_row,
  output logic [IDX_W-1:0]          word_col,
  output logic                      word_last,
  output logic                      busy
);

  import fbf_pkg::*;

  localparam int N     = DIM * DIM;
  localparam int CNT_W = 2 * IDX_W;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  state_e                  state_q;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [WORD_W*N-1:0]     mat_q;
  logic [IDX_W-1:0]        sel_row, sel_col;
  logic [WORD_W-1:0]       sel_word;
  logic                    accept;

  assign accept = (state_q == STREAM) && word_ready;
  assign busy   = (state_q != IDLE);

  // The mux looks at the element the counter will hold after this edge, so
  // the registered word lines up with word_valid without a bubble.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ACK) begin
      cnt_d = '0;
    end else if (accept) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

`ifdef FBF_UNPACK_COL_MAJOR_EN
  assign sel_row = cnt_d[IDX_W-1:0];
  assign sel_col = cnt_d[CNT_W-1:IDX_W];
`else
  assign sel_row = cnt_d[CNT_W-1:IDX_W];
  assign sel_col = cnt_d[IDX_W-1:0];
`endif

  fbf_elem_select #(
    .WORD_W (WORD_W),
    .DIM    (DIM),
    .IDX_W  (IDX_W)
  ) u_sel (
    .mat_i  (mat_q),
    .row_i  (sel_row),
    .col_i  (sel_col),
    .word_o (sel_word)
  );

  always_ff @(posedge clk) begin
    if (state_q == IDLE && result_ready) begin
      mat_q <= result;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      result_ack <= 1'b0;
      word_valid <= 1'b0;
      word_last  <= 1'b0;
      word_out   <= '0;
      word_row   <= '0;
      word_col   <= '0;
    end else begin
      cnt_q <= cnt_d;
      case (state_q)
        IDLE: begin
          if (result_ready) begin
            state_q    <= ACK;
            result_ack <= 1'b1;
          end
        end
        ACK: begin
          if (!result_ready) begin
            state_q    <= STREAM;
            result_ack <= 1'b0;
            word_valid <= 1'b1;
            word_out   <= sel_word;
            word_row   <= sel_row;
            word_col   <= sel_col;
            word_last  <= (cnt_d == LAST);
          end
        end
        STREAM: begin
          if (word_ready) begin
            if (cnt_q == LAST) begin
              state_q    <= IDLE;
              word_valid <= 1'b0;
              word_last  <= 1'b0;
            end else begin
              word_out  <= sel_word;
              word_row  <= sel_row;
              word_col  <= sel_col;
              word_last <= (cnt_d == LAST);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
